// File: rtl/sc_sng_pkg.sv
// sc_sng_pkg: FSM state type, maximal-length LFSR tap tables and seed sanitising for the gb4ed SNG
package sc_sng_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int MAXW = 16;

    function automatic logic [MAXW-1:0] taps_pri(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [MAXW-1:0] taps_alt(input int w);
        logic [MAXW-1:0] p, a;
        p = taps_pri(w);
        a = MAXW'(32'd1 << (w - 1));
        for (int b = 0; b < MAXW; b++)
            if (b < w - 1 && ((p >> b) & 16'd1) != 16'd0)
                a = a | MAXW'(32'd1 << (w - 2 - b));
        return a;
    endfunction

    function automatic logic [MAXW-1:0] seed_fix(input int s, input int w);
        logic [31:0] v;
        v = 32'(s) & ((32'd1 << w) - 32'd1);
        return MAXW'((v == 32'd0) ? 32'd1 : v);
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// sc_lfsr: Fibonacci LFSR with seed reload and step enable
module sc_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = '0,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;

    // reload wins over stepping; otherwise hold
    always_comb q_d = load ? SEED : en ? {q_q[WIDTH-2:0], ^(q_q & TAPS)} : q_q;

    // shift register state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= SEED;
        else        q_q <= q_d;

    assign q = q_q;

endmodule

// File: rtl/gb4ed_sng.sv
// gb4ed_sng: captures a pixel window and emits the 21 unipolar bitstreams for gb4ed (optional SC_SNG_SELFCHECK_EN)
module gb4ed_sng
    import sc_sng_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NPIX   = 20,
    parameter int SEED_A = 1,
    parameter int SEED_B = 'h5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NPIX*WIDTH-1:0] pix,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [NPIX:0]         x,
    output logic                  out_last,
    output logic                  err
);

    localparam logic [WIDTH-1:0] TAPS_A = WIDTH'(taps_pri(WIDTH));
    localparam logic [WIDTH-1:0] TAPS_B = WIDTH'(taps_alt(WIDTH));
    localparam logic [WIDTH-1:0] SA     = WIDTH'(seed_fix(SEED_A, WIDTH));
    localparam logic [WIDTH-1:0] SB     = WIDTH'(seed_fix(SEED_B, WIDTH));
    localparam logic [WIDTH-1:0] LAST   = WIDTH'((1 << WIDTH) - 2);

    state_t                state_q, state_d;
    logic [NPIX*WIDTH-1:0] pix_q, pix_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d, ra, rb, ra_nx, rb_nx, ra_use, rb_use;
    logic [NPIX:0]         x_q, x_d;
    logic                  accept, xfer;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    // accept a window from IDLE; leave RUN once the last slice transfers
    always_comb state_d = (state_q == IDLE) ? (in_valid ? RUN : IDLE) : ((out_ready && out_last) ? IDLE : RUN);

    // handshake outputs decoded from state and slice counter
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == RUN;
        out_last  = out_valid && cnt_q == LAST;
    end

    assign accept = in_ready && in_valid;
    assign xfer   = out_valid && out_ready;

    // LFSR output always equals the random value of the slice currently held in x
    sc_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS_A), .SEED(SA)) u_lfsr_a (
        .clk(clk), .rst_n(rst_n), .load(accept), .en(xfer), .q(ra)
    );

    sc_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS_B), .SEED(SB)) u_lfsr_b (
        .clk(clk), .rst_n(rst_n), .load(accept), .en(xfer), .q(rb)
    );

    // next slice: seeds and fresh window on accept, stepped LFSR values and held window on transfer
    always_comb begin
        ra_nx  = {ra[WIDTH-2:0], ^(ra & TAPS_A)};
        rb_nx  = {rb[WIDTH-2:0], ^(rb & TAPS_B)};
        pix_d  = accept ? pix : pix_q;
        ra_use = accept ? SA : ra_nx;
        rb_use = accept ? SB : rb_nx;
        cnt_d  = accept ? '0 : xfer ? cnt_q + WIDTH'(1) : cnt_q;
        x_d    = x_q;
        x_d[0] = (accept || xfer) ? rb_use[WIDTH-1] : x_q[0];
        for (int i = 0; i < NPIX; i++)
            x_d[i+1] = (accept || xfer) ? (pix_d[i*WIDTH +: WIDTH] >= ra_use) : x_q[i+1];
    end

    // window, slice counter and output slice registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pix_q <= '0;
            cnt_q <= '0;
            x_q   <= '0;
        end else begin
            pix_q <= pix_d;
            cnt_q <= cnt_d;
            x_q   <= x_d;
        end

    assign x = x_q;

`ifdef SC_SNG_SELFCHECK_EN
    localparam logic [WIDTH-1:0] HALF = WIDTH'(1 << (WIDTH - 1));

    logic [WIDTH-1:0] c1_q, c1_d, c0_q, c0_d;
    logic             err_q, err_d;

    // ones tallies of transferred x[1]/x[0]; the final slice is folded in when checking
    always_comb begin
        c1_d  = accept ? '0 : xfer ? c1_q + WIDTH'(x_q[1]) : c1_q;
        c0_d  = accept ? '0 : xfer ? c0_q + WIDTH'(x_q[0]) : c0_q;
        err_d = err_q || (xfer && out_last && (c1_d != pix_q[WIDTH-1:0] || c0_d != HALF));
    end

    // tally and sticky error registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            c1_q  <= '0;
            c0_q  <= '0;
            err_q <= 1'b0;
        end else begin
            c1_q  <= c1_d;
            c0_q  <= c0_d;
            err_q <= err_d;
        end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
